adder_core: RTL and testbench
=============================

Name: adder_core

Overview:
- Unsigned two-operand adder, full-width result (no overflow possible).
- Primary path is purely combinational: result settles within the same simulation step as the operands; no clock edge required.
- Secondary registered path gives a one-cycle-latency, valid-qualified copy of the result for synchronous consumers.
- Leaf arithmetic block used by datapath logic.

Parameters:
- WIDTH, 2, operand width in bits; result width is WIDTH+1.

Ports:
- clk  input  1  system clock; registered path only.
- rst_n  input  1  asynchronous active-low reset; registered path only.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- sum  output  WIDTH+1  combinational a+b.
- in_valid  input  1  qualifies a/b for capture into the registered path.
- sum_q  output  WIDTH+1  registered a+b.
- out_valid  output  1  sum_q holds a freshly captured result.
- carry_q  output  1  registered carry-out (MSB of the captured sum).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- sum = zero-extend(a) + zero-extend(b), computed at WIDTH+1 bits.
  - Never truncates, e.g. WIDTH=2: 3+3 = 6 (3'b110).
- sum is purely combinational:
  - Depends only on a and b.
  - Independent of clk, rst_n and in_valid.
  - Correct even when clk is unconnected/X and reset is never applied.
  - Zero-delay; no latches.
- Registered path, asynchronous reset:
  - rst_n low -> sum_q=0, carry_q=0, out_valid=0 immediately, without waiting for a clk edge.
  - Values hold while rst_n is low.
- Registered path, rising clk with rst_n high:
  - in_valid=1 -> sum_q <= a+b, carry_q <= (a+b)[WIDTH], out_valid <= 1.
  - in_valid=0 -> sum_q and carry_q hold their last value; out_valid <= 0.
- Latency: exactly 1 clk cycle from an in_valid sample to out_valid/sum_q.
- Back-to-back in_valid: one result per cycle, no bubbles, no backpressure (no ready signal).
- Reset mid-operation: any in-flight capture is discarded; the first valid result after release comes from the first in_valid sampled at a rising edge with rst_n high.
- Reset release is synchronous to the design's reset synchronizer upstream; this block adds none.
- Boundaries:
  - a=b=0 -> sum 0.
  - a=b=2^WIDTH-1 -> sum 2^(WIDTH+1)-2, carry 1.
- X on a or b propagates to sum; no X-masking.

Decomposition:
- adder_pkg holds:
  - Localparam DEFAULT_WIDTH=2.
  - Function add_ext(a,b) returning the WIDTH+1 zero-extended sum, used by both paths.
- One sub-module, adder_reg_stage:
  - Async-reset register of WIDTH+1 data bits plus a valid bit, with a hold-on-invalid enable.
  - Instantiated once for sum_q/carry_q/out_valid.
- Top level holds only the combinational sum and the instance.

Test Plan:
- Combinational, no clock toggling: a=2,b=1 -> sum=3 after a 1-time-unit settle; then a=1,b=1 -> sum=2.
- Full-range sweep, all 16 (a,b) pairs at WIDTH=2: sum=a+b exactly; a=3,b=3 -> sum=6, bit 2 set.
- Registered capture: reset pulse; then in_valid=1, a=2,b=1 at edge N -> after edge N, sum_q=3, carry_q=0, out_valid=1; in_valid=0 at edge N+1 -> out_valid=0, sum_q holds 3.
- Back-to-back: (3,3),(1,0),(0,0) on consecutive edges -> sum_q sequence 6,1,0 with carry_q 1,0,0 and out_valid high for 3 cycles.
- Async reset mid-stream: assert rst_n=0 between edges while out_valid=1 -> sum_q=0, out_valid=0, carry_q=0 before the next edge; sum still equals current a+b throughout.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and zero-extending add helper for adder_core
//
// Purpose: holds the default operand width and the add_ext helper used by both
// the combinational and registered result paths.
// Ports: none (package).
package adder_pkg;

    localparam int DEFAULT_WIDTH = 2;

    // Widest operand the helper supports; callers zero-extend their operands
    // to this width and size-cast the result back to WIDTH+1 bits.
    localparam int MAX_WIDTH = 32;

    // Zero-extended sum at MAX_WIDTH+1 bits. Plain combinational '+' so an X
    // on either operand propagates to the result.
    function automatic logic [MAX_WIDTH:0] add_ext(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_reg_stage.sv
// rtl/adder_reg_stage.sv - async-reset data register with valid bit and hold-on-invalid
//
// Purpose: captures i_d when i_en is high at a rising clk; otherwise holds the
// data and drops o_valid. rst_n low clears everything immediately.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   i_en     in   capture enable / input valid
//   i_d      in   DW-bit data to capture
//   o_q      out  DW-bit captured data
//   o_valid  out  high for the cycle after a capture
module adder_reg_stage
    import adder_pkg::*;
#(
    parameter int DW = DEFAULT_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q,
    output logic          o_valid
);

    logic [DW-1:0] r_q;
    logic          r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else begin
            // Valid is a one-cycle pulse per capture; data holds when idle.
            r_valid <= i_en;
            if (i_en) begin
                r_q <= i_d;
            end
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule

// File: rtl/adder_core.sv
// rtl/adder_core.sv - unsigned full-width adder with combinational and registered results
//
// Purpose: sum is a+b at WIDTH+1 bits, purely combinational. sum_q/carry_q/
// out_valid give a one-cycle-latency registered copy, captured on in_valid.
// Ports:
//   clk        in   clock (registered path only)
//   rst_n      in   asynchronous active-low reset (registered path only)
//   a, b       in   WIDTH-bit unsigned operands
//   sum        out  WIDTH+1-bit combinational a+b
//   in_valid   in   qualifies a/b for capture
//   sum_q      out  WIDTH+1-bit registered a+b
//   out_valid  out  sum_q holds a freshly captured result
//   carry_q    out  registered carry-out (MSB of sum_q)
module adder_core
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum,
    input  logic             in_valid,
    output logic [WIDTH:0]   sum_q,
    output logic             out_valid,
    output logic             carry_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_q;

    // Operands zero-extend into the helper; the size cast keeps only the
    // WIDTH+1 meaningful result bits.
    assign w_sum = (WIDTH+1)'(add_ext(MAX_WIDTH'(a), MAX_WIDTH'(b)));
    assign sum   = w_sum;

    adder_reg_stage #(
        .DW (WIDTH + 1)
    ) u_reg_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (in_valid),
        .i_d     (w_sum),
        .o_q     (w_q),
        .o_valid (out_valid)
    );

    assign sum_q   = w_q;
    // Carry is the captured MSB, so it can never disagree with sum_q.
    assign carry_q = w_q[WIDTH];

endmodule

// File: tb/tb_adder_core.sv
// tb/tb_adder_core.sv - scoreboard testbench for adder_core (WIDTH=2)
module tb_adder_core;

    typedef struct packed {
        logic [2:0] s;
        logic       c;
    } exp_t;

    logic       clk = 1'b0;
    bit         clk_en = 1'b0;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] sum;
    logic       in_valid;
    logic [2:0] sum_q;
    logic       out_valid;
    logic       carry_q;

    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    exp_t sb[$];

    adder_core #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .in_valid  (in_valid),
        .sum_q     (sum_q),
        .out_valid (out_valid),
        .carry_q   (carry_q)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after a falling edge; a valid beat
    // queues its hand-computed registered result.
    task automatic step(input logic v, input logic [1:0] x, input logic [1:0] y,
                        input logic [2:0] es, input logic ec);
        exp_t e;
        @(negedge clk);
        #1;
        in_valid = v;
        a = x;
        b = y;
        if (v) begin
            e.s = es;
            e.c = ec;
            sb.push_back(e);
        end
    endtask

    // Monitor: every presented result is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: got sum_q=%0d with no pending result", sum_q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                pops++;
                if (sum_q !== e.s || carry_q !== e.c) begin
                    errors++;
                    $display("FAIL sb_result: got sum_q=%0d carry_q=%0d expected sum_q=%0d carry_q=%0d",
                             sum_q, carry_q, e.s, e.c);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Combinational path with the clock stopped and reset never applied.
        a = 2'd2; b = 2'd1; #1;
        chk("comb_2p1", 32'(sum), 32'd3);
        a = 2'd1; b = 2'd1; #1;
        chk("comb_1p1", 32'(sum), 32'd2);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a = 2'(i); b = 2'(j); #1;
                chk($sformatf("sweep_%0d_%0d", i, j), 32'(sum), i + j);
            end
        end
        a = 2'd3; b = 2'd3; #1;
        chk("max_sum_bit2", 32'(sum[2]), 32'd1);

        // Async reset before any clock edge.
        clk_en = 1'b1;
        rst_n = 1'b0; #1;
        chk("rst_sum_q", 32'(sum_q), 32'd0);
        chk("rst_carry_q", 32'(carry_q), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;

        // Single capture then idle: valid drops, data holds.
        step(1'b1, 2'd2, 2'd1, 3'd3, 1'b0);
        step(1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        @(posedge clk); #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_sum_q", 32'(sum_q), 32'd3);
        chk("idle_hold_carry_q", 32'(carry_q), 32'd0);

        // Back-to-back results, one per cycle.
        p0 = pops;
        step(1'b1, 2'd3, 2'd3, 3'd6, 1'b1);
        step(1'b1, 2'd1, 2'd0, 3'd1, 1'b0);
        step(1'b1, 2'd0, 2'd0, 3'd0, 1'b0);
        step(1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        @(negedge clk); #1;
        chk("b2b_count", pops - p0, 32'd3);

        // Async reset while a result is presented.
        step(1'b1, 2'd2, 2'd2, 3'd4, 1'b0);
        @(posedge clk); #2;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_sum_q", 32'(sum_q), 32'd4);
        rst_n = 1'b0; #1;
        chk("mid_rst_sum_q", 32'(sum_q), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_carry_q", 32'(carry_q), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd4);
        // The presented result was wiped by reset, so it will never be seen.
        sb.delete();
        in_valid = 1'b1; a = 2'd3; b = 2'd2; #1;
        chk("rst_comb_sum", 32'(sum), 32'd5);
        @(posedge clk); #1;
        chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_sum_q", 32'(sum_q), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;

        p0 = pops;
        step(1'b1, 2'd1, 2'd2, 3'd3, 1'b0);
        step(1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        @(negedge clk); #1;
        chk("post_rst_count", pops - p0, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
